sr_cmd_debounce: RTL and testbench

//   Upstream driver for the gated SR latch: turns two raw, bouncy, asynchronous
//   set/clear push-button lines into clean single-cycle S/R/En commands.

---
 rtl/sr_pkg.sv | 13 +
 rtl/sr_debounce_ch.sv | 42 ++++
 rtl/sr_cmd_debounce.sv | 96 +++++++++
 tb/tb_sr_cmd_debounce.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch command front end: FSM encoding and the
// default debounce length.
package sr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int DEB_CYCLES_DEF = 4;

endpackage

// File: rtl/sr_debounce_ch.sv
// One button channel: 2-FF synchroniser followed by a run-length debouncer
// that only accepts a new level after DEB_CYCLES unbroken matching samples.
module sr_debounce_ch
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any sample that agrees with the accepted level restarts the run.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_debounce.sv
// Debounces raw set/clear buttons and issues one registered S/R/En command per
// press. Optional macro SR_CMD_SET_PRIO_EN turns a simultaneous press into a set.
//
//   state | meaning
//   IDLE  | waiting for exactly one debounced button to go high
//   CMD   | the single cycle in which S/R/En are presented to the latch
//   HOLD  | press consumed; wait for both buttons released
module sr_cmd_debounce
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set_raw,
  input  logic clr_raw,
  output logic S,
  output logic R,
  output logic En,
  output logic cmd_drop
);

  logic   set_stable;
  logic   clr_stable;
  state_t state_q;
  state_t state_d;
  logic   s_d;
  logic   r_d;
  logic   en_d;
  logic   drop_d;

  sr_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_set_ch (
    .clk    (clk),
    .rst    (rst),
    .raw    (set_raw),
    .stable (set_stable)
  );

  sr_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_clr_ch (
    .clk    (clk),
    .rst    (rst),
    .raw    (clr_raw),
    .stable (clr_stable)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      S        <= 1'b0;
      R        <= 1'b0;
      En       <= 1'b0;
      cmd_drop <= 1'b0;
    end else begin
      state_q  <= state_d;
      S        <= s_d;
      R        <= r_d;
      En       <= en_d;
      cmd_drop <= drop_d;
    end
  end

  // Outputs are computed for the state being entered, so they are high
  // exactly while state_q == ST_CMD (or for one cycle on a dropped press).
  always_comb begin
    state_d = state_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    en_d    = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (set_stable ^ clr_stable) begin
          state_d = ST_CMD;
          s_d     = set_stable;
          r_d     = clr_stable;
          en_d    = 1'b1;
        end else if (set_stable && clr_stable) begin
`ifdef SR_CMD_SET_PRIO_EN
          state_d = ST_CMD;
          s_d     = 1'b1;
          en_d    = 1'b1;
`else
          state_d = ST_HOLD;
          drop_d  = 1'b1;
`endif
        end
      end
      ST_CMD: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!set_stable && !clr_stable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Directed bench for sr_cmd_debounce: per-edge stimulus vectors, observed
// pulses recorded per run and compared against hand-derived edge numbers.
module tb_sr_cmd_debounce;

  logic clk = 1'b0;
  logic rst;
  logic set_raw;
  logic clr_raw;
  logic S;
  logic R;
  logic En;
  logic cmd_drop;

  int n_checks = 0;
  int n_pass   = 0;

  int en_cnt;
  int drop_cnt;
  int drop_edge;
  int first_en;
  int last_en;
  logic fs, fr, ls, lr;
  int viol;

  sr_cmd_debounce #(.DEB_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .set_raw  (set_raw),
    .clr_raw  (clr_raw),
    .S        (S),
    .R        (R),
    .En       (En),
    .cmd_drop (cmd_drop)
  );

  always #5 clk = ~clk;

  // Bits for edges lo..hi (1-based) set.
  function automatic logic [63:0] ones(input int lo, input int hi);
    logic [63:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i-1] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; set_raw = 1'b0; clr_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drives edge k with bit k-1 of each vector, samples #1 after each edge.
  task automatic apply(input logic [63:0] sv, input logic [63:0] cv,
                       input logic [63:0] rv, input int n);
    en_cnt = 0; drop_cnt = 0; drop_edge = -1; first_en = -1; last_en = -1;
    fs = 1'b0; fr = 1'b0; ls = 1'b0; lr = 1'b0; viol = 0;
    for (int k = 1; k <= n; k++) begin
      set_raw = sv[k-1]; clr_raw = cv[k-1]; rst = rv[k-1];
      @(posedge clk);
      #1;
      if (En === 1'b1) begin
        en_cnt++;
        if (first_en < 0) begin first_en = k; fs = S; fr = R; end
        last_en = k; ls = S; lr = R;
      end
      if (cmd_drop === 1'b1) begin drop_cnt++; drop_edge = k; end
      if (((S | R) && !En) || (En && (S == R)) || $isunknown({S, R, En, cmd_drop})) viol++;
    end
    rst = 1'b0; set_raw = 1'b0; clr_raw = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_raw = 1'b0; clr_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({S, R, En, cmd_drop} !== 4'b0000)
        $display("FAIL reset_during got=%b want=0000", {S, R, En, cmd_drop});
      else n_pass++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({S, R, En, cmd_drop} !== 4'b0000)
        $display("FAIL reset_after got=%b want=0000", {S, R, En, cmd_drop});
      else n_pass++;
    end
  endtask

  task automatic test_single_set();
    do_reset();
    apply(ones(1, 20), '0, '0, 30);
    n_checks++; if (en_cnt !== 1) $display("FAIL set_en_count got=%0d want=1", en_cnt); else n_pass++;
    n_checks++; if (first_en !== 7) $display("FAIL set_en_edge got=%0d want=7", first_en); else n_pass++;
    n_checks++; if ({fs, fr} !== 2'b10) $display("FAIL set_sr got=%b want=10", {fs, fr}); else n_pass++;
    n_checks++; if (drop_cnt !== 0) $display("FAIL set_drop got=%0d want=0", drop_cnt); else n_pass++;
    n_checks++; if (viol !== 0) $display("FAIL set_invariant got=%0d want=0", viol); else n_pass++;
  endtask

  task automatic test_bounce();
    logic [63:0] sv;
    do_reset();
    sv = ones(1, 2) | ones(4, 5) | ones(7, 30);
    apply(sv, '0, '0, 30);
    n_checks++; if (en_cnt !== 1) $display("FAIL bounce_en_count got=%0d want=1", en_cnt); else n_pass++;
    n_checks++; if (first_en !== 13) $display("FAIL bounce_en_edge got=%0d want=13", first_en); else n_pass++;
    n_checks++; if ({fs, fr} !== 2'b10) $display("FAIL bounce_sr got=%b want=10", {fs, fr}); else n_pass++;
  endtask

  task automatic test_conflict();
    do_reset();
    apply(ones(1, 20), ones(1, 20), '0, 30);
    n_checks++; if (viol !== 0) $display("FAIL conflict_invariant got=%0d want=0", viol); else n_pass++;
`ifdef SR_CMD_SET_PRIO_EN
    n_checks++; if (en_cnt !== 1) $display("FAIL prio_en_count got=%0d want=1", en_cnt); else n_pass++;
    n_checks++; if (first_en !== 7) $display("FAIL prio_en_edge got=%0d want=7", first_en); else n_pass++;
    n_checks++; if ({fs, fr} !== 2'b10) $display("FAIL prio_sr got=%b want=10", {fs, fr}); else n_pass++;
    n_checks++; if (drop_cnt !== 0) $display("FAIL prio_drop got=%0d want=0", drop_cnt); else n_pass++;
`else
    n_checks++; if (en_cnt !== 0) $display("FAIL drop_en_count got=%0d want=0", en_cnt); else n_pass++;
    n_checks++; if (drop_cnt !== 1) $display("FAIL drop_count got=%0d want=1", drop_cnt); else n_pass++;
    n_checks++; if (drop_edge !== 7) $display("FAIL drop_edge got=%0d want=7", drop_edge); else n_pass++;
`endif
  endtask

  task automatic test_hold_then_clr();
    do_reset();
    apply(ones(1, 20), ones(10, 20) | ones(31, 50), '0, 50);
    n_checks++; if (en_cnt !== 2) $display("FAIL hold_en_count got=%0d want=2", en_cnt); else n_pass++;
    n_checks++; if (first_en !== 7) $display("FAIL hold_first_edge got=%0d want=7", first_en); else n_pass++;
    n_checks++; if (last_en !== 37) $display("FAIL hold_clr_edge got=%0d want=37", last_en); else n_pass++;
    n_checks++; if ({ls, lr} !== 2'b01) $display("FAIL hold_clr_sr got=%b want=01", {ls, lr}); else n_pass++;
    n_checks++; if (drop_cnt !== 0) $display("FAIL hold_drop got=%0d want=0", drop_cnt); else n_pass++;
    n_checks++; if (viol !== 0) $display("FAIL hold_invariant got=%0d want=0", viol); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(ones(1, 30), '0, ones(5, 5), 30);
    n_checks++; if (en_cnt !== 1) $display("FAIL rstmid_en_count got=%0d want=1", en_cnt); else n_pass++;
    n_checks++; if (first_en !== 12) $display("FAIL rstmid_en_edge got=%0d want=12", first_en); else n_pass++;
    n_checks++; if (viol !== 0) $display("FAIL rstmid_invariant got=%0d want=0", viol); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; set_raw = 1'b0; clr_raw = 1'b0;
    test_reset();
    test_single_set();
    test_bounce();
    test_conflict();
    test_hold_then_clr();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
